// File: rtl/lif_neuron_array.sv
// Bank of NUM_CH leaky integrate-and-fire neurons with shift-based leak,
// saturating integration, shared threshold and absolute refractory period.
module lif_neuron_array #(
  parameter int NUM_CH       = 4,
  parameter int WIDTH        = 8,
  parameter int LEAK_SHIFT   = 4,
  parameter int REFRAC_TICKS = 2,
  parameter int V_RESET      = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [NUM_CH-1:0]         chan_en,
  input  logic [NUM_CH*WIDTH-1:0]   i_ext,
  input  logic [WIDTH-1:0]          thresh,
  output logic [NUM_CH-1:0]         spike,
  output logic [NUM_CH*WIDTH-1:0]   voltage,
  output logic [NUM_CH-1:0]         in_refr,
  output logic [NUM_CH-1:0]         o_dbg_state
);

  // Interface timing: there is no handshake. Inputs are sampled only on a
  // clk edge with tick high; the results are valid from the following cycle
  // and hold until the next tick. spike is a one-cycle pulse.

  typedef enum logic {
    ST_INTEGRATE  = 1'b0,
    ST_REFRACTORY = 1'b1
  } state_t;

  localparam int CW = (REFRAC_TICKS > 0) ? $clog2(REFRAC_TICKS + 1) : 1;
  localparam logic [WIDTH-1:0] V_RST = WIDTH'(V_RESET);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [WIDTH-1:0] r_v;
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_spike;

    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_leak;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_vnext;
    logic             w_fire;

    assign w_in    = i_ext[k*WIDTH +: WIDTH];
    // A shift of zero means no leak, not a full discharge.
    assign w_leak  = (LEAK_SHIFT == 0) ? '0 : (r_v >> LEAK_SHIFT);
    assign w_sum   = {1'b0, r_v} - {1'b0, w_leak} + {1'b0, w_in};
    assign w_vnext = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    assign w_fire  = (w_vnext >= thresh);

    always_ff @(posedge clk) begin
      if (reset) begin
        r_v     <= '0;
        r_state <= ST_INTEGRATE;
        r_cnt   <= '0;
        r_spike <= 1'b0;
      end else begin
        r_spike <= 1'b0;
        if (tick) begin
          if (!chan_en[k]) begin
            r_v     <= '0;
            r_state <= ST_INTEGRATE;
            r_cnt   <= '0;
          end else begin
            case (r_state)
              ST_INTEGRATE: begin
                if (w_fire) begin
                  r_spike <= 1'b1;
                  r_v     <= V_RST;
                  if (REFRAC_TICKS > 0) begin
                    r_state <= ST_REFRACTORY;
                    r_cnt   <= CW'(REFRAC_TICKS);
                  end
                end else begin
                  r_v <= w_vnext;
                end
              end
              ST_REFRACTORY: begin
                r_v <= V_RST;
                if (r_cnt <= CW'(1)) begin
                  r_cnt   <= '0;
                  r_state <= ST_INTEGRATE;
                end else begin
                  r_cnt <= r_cnt - CW'(1);
                end
              end
              default: begin
                r_v     <= '0;
                r_state <= ST_INTEGRATE;
                r_cnt   <= '0;
              end
            endcase
          end
        end
      end
    end

    assign spike[k]                 = r_spike;
    assign voltage[k*WIDTH +: WIDTH] = r_v;
    assign in_refr[k]               = (r_state == ST_REFRACTORY);
    assign o_dbg_state[k]           = r_state;
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array: drivers push hand-computed expectations
// into a queue; a negedge monitor pops and compares them against the outputs.
module tb_lif_neuron_array;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    tick;
  logic [NUM_CH-1:0]       chan_en;
  logic [NUM_CH*WIDTH-1:0] i_ext;
  logic [WIDTH-1:0]        thresh;
  logic [NUM_CH-1:0]       spike;
  logic [NUM_CH*WIDTH-1:0] voltage;
  logic [NUM_CH-1:0]       in_refr;
  logic [NUM_CH-1:0]       o_dbg_state;

  lif_neuron_array #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .LEAK_SHIFT(4), .REFRAC_TICKS(2), .V_RESET(0)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .chan_en(chan_en), .i_ext(i_ext),
    .thresh(thresh), .spike(spike), .voltage(voltage), .in_refr(in_refr),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // entry: {due_cycle[27:12], ch[11:10], v[9:2], spike[1], refr[0]}
  logic [27:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // driver tasks
  task automatic drive(input logic t, input logic r, input logic [3:0] en,
                       input logic [31:0] ie, input logic [7:0] th);
    @(negedge clk);
    tick = t; reset = r; chan_en = en; i_ext = ie; thresh = th;
  endtask

  task automatic exp_ch(input int ch, input int v, input int sp, input int rf);
    logic [27:0] e;
    e = {16'(cyc + 1), 2'(ch), 8'(v), 1'(sp), 1'(rf)};
    exp_q.push_back(e);
  endtask

  task automatic exp_all_zero();
    for (int c = 0; c < NUM_CH; c++) exp_ch(c, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b1, 4'hF, 32'd0, 8'd0);
      exp_all_zero();
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [27:0] e;
    int ch;
    logic [7:0] ev;
    logic es, er;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && int'(exp_q[0][27:12]) <= cyc) begin
        e  = exp_q.pop_front();
        ch = int'(e[11:10]);
        ev = e[9:2];
        es = e[1];
        er = e[0];
        n_tests++;
        if (voltage[ch*WIDTH +: WIDTH] !== ev || spike[ch] !== es || in_refr[ch] !== er) begin
          n_fail++;
          $display("FAIL ch%0d cyc%0d: got v=%0d spike=%b refr=%b, expected v=%0d spike=%b refr=%b",
                   ch, cyc, voltage[ch*WIDTH +: WIDTH], spike[ch], in_refr[ch], ev, es, er);
        end
      end
    end
  end

  initial begin
    int v6 [10] = '{10, 0, 0, 0, 10, 0, 0, 0, 10, 0};
    int sp6[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    int rf6[10] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    int en6[10] = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
    int v1 [8]  = '{0, 4, 8, 12, 16, 19, 0, 0};
    int s1 [8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
    int r1 [8]  = '{0, 0, 0, 0, 0, 0, 1, 1};
    int v0 [4]  = '{0, 10, 0, 0};
    int s0 [4]  = '{0, 0, 1, 0};
    int r0 [4]  = '{0, 0, 1, 1};
    int wait_n;

    tick = 1'b0; reset = 1'b1; chan_en = '0; i_ext = '0; thresh = '0;

    // reset with tick high: everything must stay cleared
    do_reset(5);

    // ch0 i=10, ch1 i=4, ch2 i=1, ch3 i=0, thresh=20, all in parallel
    for (int t = 1; t <= 300; t++) begin
      drive(1'b1, 1'b0, 4'hF, {8'd0, 8'd1, 8'd4, 8'd10}, 8'd20);
      exp_ch(0, v0[t % 4], s0[t % 4], r0[t % 4]);
      exp_ch(1, v1[t % 8], s1[t % 8], r1[t % 8]);
      exp_ch(2, (t < 16) ? t : 16, 0, 0);
      exp_ch(3, 0, 0, 0);
    end

    // ch3 i=200, thresh=255: 200 then 388 saturates to 255 and fires
    do_reset(2);
    for (int t = 1; t <= 8; t++) begin
      drive(1'b1, 1'b0, 4'hF, {8'd200, 24'd0}, 8'd255);
      exp_ch(3, (t % 4 == 1) ? 200 : 0, (t % 4 == 2) ? 1 : 0,
             (t % 4 == 2 || t % 4 == 3) ? 1 : 0);
      exp_ch(0, 0, 0, 0);
    end

    // thresh=0: every integrate tick fires, period 1 + 2 refractory
    do_reset(1);
    for (int t = 1; t <= 6; t++) begin
      drive(1'b1, 1'b0, 4'hF, 32'd0, 8'd0);
      for (int c = 0; c < NUM_CH; c++)
        exp_ch(c, 0, (t % 3 == 1) ? 1 : 0, (t % 3 == 0) ? 0 : 1);
    end

    // reset one clk after a spike, while refractory
    do_reset(1);
    drive(1'b1, 1'b0, 4'hF, 32'd10, 8'd20); exp_ch(0, 10, 0, 0);
    drive(1'b1, 1'b0, 4'hF, 32'd10, 8'd20); exp_ch(0, 0, 1, 1);
    drive(1'b1, 1'b1, 4'hF, 32'd10, 8'd20); exp_all_zero();
    drive(1'b1, 1'b0, 4'hF, 32'd10, 8'd20); exp_ch(0, 10, 0, 0);
    drive(1'b1, 1'b0, 4'hF, 32'd10, 8'd20); exp_ch(0, 0, 1, 1);

    // tick every 3rd clk, ch0 disabled for ticks 6..8, junk inputs between ticks
    do_reset(1);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, {3'b111, 1'(en6[k])}, 32'd10, 8'd20);
      exp_ch(0, v6[k], sp6[k], rf6[k]);
      for (int h = 0; h < 2; h++) begin
        drive(1'b0, 1'b0, {3'b111, 1'(en6[k])}, 32'd99, 8'd0);
        exp_ch(0, v6[k], 0, rf6[k]);
        exp_ch(1, 0, 0, 0);
      end
    end
    drive(1'b0, 1'b0, 4'hF, 32'd0, 8'd20);

    wait_n = 0;
    while (exp_q.size() > 0 && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
